ifft_core: RTL and testbench
============================

# ifft_core

Sequential radix-2 decimation-in-time inverse FFT over an N-point complex frame of 8-bit signed samples. It is the return path of the one-dimension FFT chain: it turns frequency-domain bins back into time-domain samples. A single butterfly unit is time-shared over an in-place register buffer. Frames enter and leave as streams with valid/ready handshakes. Output is scaled by 1/N.

## Interface
- `N`, 16, frame length; power of two, 4..64
- `LOG2N`, 4, log2(N)
- `DW`, 8, sample width, signed two's complement
- `TW`, 8, twiddle width, signed Q1.6 (64 = 1.0)

- `clk` input 1: the only clock; all state updates on the rising edge
- `rst` input 1: asynchronous, active-low reset
- `in_valid` input 1: input sample valid
- `in_ready` output 1: core accepts input (LOAD state)
- `in_re` input DW: bin real part
- `in_im` input DW: bin imaginary part
- `out_valid` output 1: output sample valid
- `out_ready` input 1: downstream accepts output
- `out_re` output DW: time-sample real part
- `out_im` output DW: time-sample imaginary part
- `out_last` output 1: marks sample N-1 of the frame
- `busy` output 1: high in COMPUTE and UNLOAD

## Operation
- FSM states: LOAD → COMPUTE → UNLOAD → LOAD. Reset state is LOAD.
- LOAD
  - `in_ready`=1.
  - Each handshake writes the sample to buffer[bitrev(in_cnt)].
  - The handshake with in_cnt=N-1 moves the FSM to COMPUTE and clears in_cnt.
- COMPUTE: one butterfly per cycle. Stage s runs 0..LOG2N-1; butterfly b runs 0..N/2-1.
  - half=1<<s, pos=b&(half-1)
  - i0=((b>>s)<<(s+1))+pos, i1=i0+half
  - k=pos<<(LOG2N-1-s)
- Twiddle is W=cos(2πk/N)+j·sin(2πk/N), the inverse sign.
- Butterfly arithmetic:
  - tr=(Br·Wr−Bi·Wi)>>>6 and ti=(Br·Wi+Bi·Wr)>>>6, full-width products, arithmetic shift (floor).
  - A'=(A+t)>>>1 and B'=(A−t)>>>1, computed at DW+2 bits, then saturated to [−2^(DW−1), 2^(DW−1)−1].
  - A' and B' are written back to i0 and i1 on the same edge.
- The last butterfly of the last stage moves the FSM to UNLOAD.
- UNLOAD
  - `out_valid`=1.
  - `out_re`/`out_im`=buffer[out_cnt] in natural order.
  - `out_last`=1 when out_cnt=N-1.
  - out_cnt advances only on a `out_valid`&&`out_ready` handshake.
  - The handshake on the last sample moves the FSM to LOAD.
- `in_valid` outside LOAD is ignored and does not stall the FSM.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `out_re`=`out_im`=0; counters and buffer are cleared.
- Reset asserted in any state, including mid-COMPUTE or mid-UNLOAD, aborts the frame. Outputs take their reset values immediately, without waiting for a clock edge.
- COMPUTE lasts exactly LOG2N·N/2 cycles (32 at N=16).
- `out_valid` rises in the cycle after the final butterfly edge. That is LOG2N·N/2+1 cycles after the edge accepting input sample N-1 (33 at N=16).
- While `out_valid`=1 and `out_ready`=0, `out_re`, `out_im` and `out_last` hold stable.
- `in_ready` rises in the cycle after the last output handshake. The core is not pipelined: a frame takes at least 2N+LOG2N·N/2 cycles.
- `out_re`/`out_im` are 0 whenever `out_valid`=0.

## Structure
- Package `ifft_pkg` holds:
  - constants `DW`, `TW` and `NMAX`=64;
  - the Q1.6 twiddle tables `TW_COS` and `TW_SIN`, round(64·cos/sin(2πk/64)) for k=0..31;
  - the state enum (LOAD, COMPUTE, UNLOAD);
  - a `bitrev` function.
- The core indexes the tables at k·(NMAX/N).
- Sub-module `ifft_butterfly` is combinational. It performs the complex multiply, add/subtract, halving and saturation. It is instantiated once in `ifft_core`, which owns the FSM, counters and buffer.

## Test plan
- Reset: hold `rst`=0 then release → `in_ready`=1, `out_valid`=0, `busy`=0, `out_re`=`out_im`=0.
- Impulse bin: X[0]=(64,0), all other bins 0 → 16 outputs, all (4,0). `out_last` is high only on the 16th; `out_valid` rises 33 cycles after the last input accept.
- Flat spectrum: all X=(16,0) → out[0]=(16,0), out[1..15]=(0,0).
- Single tone: X[1]=(64,0), others 0 → out[0]=(4,0), out[4]=(0,4), out[8]=(−4,0), out[12]=(0,−4), each within ±1 LSB. This checks the inverse twiddle sign.
- Backpressure: drop `out_ready` for 5 cycles at output index 3 → data stable and `out_valid` held, no sample dropped or duplicated. Driving `in_valid`=1 throughout COMPUTE/UNLOAD → `in_ready`=0 and the frame result is unchanged.
- Mid-frame reset: assert `rst` during COMPUTE stage 2 → `busy`=0 and `in_ready`=1 immediately. The next frame (impulse case) yields all (4,0).

Source files
------------

// File: rtl/ifft_pkg.sv
// Shared constants, Q1.6 twiddle tables, FSM state type and bit-reversal helper
// for the sequential inverse FFT core.
package ifft_pkg;

    localparam int DW   = 8;
    localparam int TW   = 8;
    localparam int NMAX = 64;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } state_e;

    // round(64*cos(2*pi*k/64)) and round(64*sin(2*pi*k/64)), k = 0..31
    localparam logic signed [TW-1:0] TW_COS [0:NMAX/2-1] = '{
        8'sd64,  8'sd64,  8'sd63,  8'sd61,  8'sd59,  8'sd56,  8'sd53,  8'sd49,
        8'sd45,  8'sd41,  8'sd36,  8'sd30,  8'sd24,  8'sd19,  8'sd12,  8'sd6,
        8'sd0,  -8'sd6,  -8'sd12, -8'sd19, -8'sd24, -8'sd30, -8'sd36, -8'sd41,
        -8'sd45, -8'sd49, -8'sd53, -8'sd56, -8'sd59, -8'sd61, -8'sd63, -8'sd64
    };

    localparam logic signed [TW-1:0] TW_SIN [0:NMAX/2-1] = '{
        8'sd0,   8'sd6,   8'sd12,  8'sd19,  8'sd24,  8'sd30,  8'sd36,  8'sd41,
        8'sd45,  8'sd49,  8'sd53,  8'sd56,  8'sd59,  8'sd61,  8'sd63,  8'sd64,
        8'sd64,  8'sd64,  8'sd63,  8'sd61,  8'sd59,  8'sd56,  8'sd53,  8'sd49,
        8'sd45,  8'sd41,  8'sd36,  8'sd30,  8'sd24,  8'sd19,  8'sd12,  8'sd6
    };

    // Reverse the low 'bits' bits of v (bits <= 6).
    function automatic logic [5:0] bitrev(input logic [5:0] v, input int bits);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i] = v[5-i];
        end
        return r >> (6 - bits);
    endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 inverse butterfly: t = B*W in Q1.6, then (A+t)/2 and
// (A-t)/2 with floor shifts and saturation back to the sample width.
module ifft_butterfly #(
    parameter int DW   = 8,
    parameter int TW   = 8,
    parameter int FRAC = 6
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [DW-1:0] y0_re,
    output logic signed [DW-1:0] y0_im,
    output logic signed [DW-1:0] y1_re,
    output logic signed [DW-1:0] y1_im
);
    import ifft_pkg::*;

    localparam int PW = DW + TW;
    localparam int SW = DW + 2;
    localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > (SW)'(OUT_MAX)) begin
            return OUT_MAX;
        end else if (v < (SW)'(OUT_MIN)) begin
            return OUT_MIN;
        end else begin
            return (DW)'(v);
        end
    endfunction

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PW:0]   acc_re, acc_im;
    logic signed [SW-1:0] t_re, t_im, a_re_x, a_im_x;

    always_comb begin
        p_rr   = (PW)'(b_re) * (PW)'(w_re);
        p_ii   = (PW)'(b_im) * (PW)'(w_im);
        p_ri   = (PW)'(b_re) * (PW)'(w_im);
        p_ir   = (PW)'(b_im) * (PW)'(w_re);
        acc_re = (PW+1)'(p_rr) - (PW+1)'(p_ii);
        acc_im = (PW+1)'(p_ri) + (PW+1)'(p_ir);
        // |t| never exceeds 2^(DW), so DW+2 bits hold A+t without overflow
        t_re   = (SW)'(acc_re >>> FRAC);
        t_im   = (SW)'(acc_im >>> FRAC);
        a_re_x = (SW)'(a_re);
        a_im_x = (SW)'(a_im);
        y0_re  = sat((a_re_x + t_re) >>> 1);
        y0_im  = sat((a_im_x + t_im) >>> 1);
        y1_re  = sat((a_re_x - t_re) >>> 1);
        y1_im  = sat((a_im_x - t_im) >>> 1);
    end

endmodule

// File: rtl/ifft_core.sv
// Sequential in-place radix-2 DIT inverse FFT: loads a bit-reversed frame, runs
// LOG2N*N/2 butterflies on one shared unit, then streams the result out.
module ifft_core #(
    parameter int N     = 16,
    parameter int LOG2N = 4,
    parameter int DW    = 8,
    parameter int TW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last,
    output logic          busy
);
    import ifft_pkg::*;

    localparam int NB = N / 2;

    state_e state_q, state_d;
    logic [LOG2N-1:0] in_cnt_q, in_cnt_d;
    logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
    logic [LOG2N-1:0] bfly_q, bfly_d;
    logic [2:0]       stage_q, stage_d;

    logic signed [DW-1:0] buf_re_q [N];
    logic signed [DW-1:0] buf_im_q [N];
    logic signed [DW-1:0] buf_re_d [N];
    logic signed [DW-1:0] buf_im_d [N];

    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_re_q, out_re_d;
    logic [DW-1:0] out_im_q, out_im_d;

    logic [LOG2N-1:0] half, pos, i0, i1, k, ld_idx;
    logic [4:0]       tw_idx;

    logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;

    // Butterfly addressing for the current (stage, butterfly) pair
    always_comb begin
        half   = (LOG2N)'(1) << stage_q;
        pos    = bfly_q & (half - (LOG2N)'(1));
        i0     = ((bfly_q >> stage_q) << (stage_q + 3'd1)) + pos;
        i1     = i0 + half;
        k      = pos << (3'(LOG2N - 1) - stage_q);
        tw_idx = 5'(k) * 5'(NMAX / N);
        ld_idx = (LOG2N)'(bitrev(6'(in_cnt_q), LOG2N));
    end

    ifft_butterfly #(
        .DW   (DW),
        .TW   (TW),
        .FRAC (6)
    ) u_bfly (
        .a_re  (buf_re_q[i0]),
        .a_im  (buf_im_q[i0]),
        .b_re  (buf_re_q[i1]),
        .b_im  (buf_im_q[i1]),
        .w_re  (TW_COS[tw_idx]),
        .w_im  (TW_SIN[tw_idx]),
        .y0_re (y0_re),
        .y0_im (y0_im),
        .y1_re (y1_re),
        .y1_im (y1_im)
    );

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        bfly_d    = bfly_q;
        stage_d   = stage_q;
        for (int i = 0; i < N; i++) begin
            buf_re_d[i] = buf_re_q[i];
            buf_im_d[i] = buf_im_q[i];
        end

        case (state_q)
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    buf_re_d[ld_idx] = in_re;
                    buf_im_d[ld_idx] = in_im;
                    if (in_cnt_q == (LOG2N)'(N - 1)) begin
                        in_cnt_d = '0;
                        state_d  = COMPUTE;
                    end else begin
                        in_cnt_d = in_cnt_q + (LOG2N)'(1);
                    end
                end
            end
            COMPUTE: begin
                buf_re_d[i0] = y0_re;
                buf_im_d[i0] = y0_im;
                buf_re_d[i1] = y1_re;
                buf_im_d[i1] = y1_im;
                if (bfly_q == (LOG2N)'(NB - 1)) begin
                    bfly_d = '0;
                    if (stage_q == 3'(LOG2N - 1)) begin
                        stage_d = '0;
                        state_d = UNLOAD;
                    end else begin
                        stage_d = stage_q + 3'd1;
                    end
                end else begin
                    bfly_d = bfly_q + (LOG2N)'(1);
                end
            end
            UNLOAD: begin
                if (out_valid_q && out_ready) begin
                    if (out_cnt_q == (LOG2N)'(N - 1)) begin
                        out_cnt_d = '0;
                        state_d   = LOAD;
                    end else begin
                        out_cnt_d = out_cnt_q + (LOG2N)'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        // Outputs are registered from next-state so they line up with state_q
        in_ready_d  = (state_d == LOAD);
        busy_d      = (state_d != LOAD);
        out_valid_d = (state_d == UNLOAD);
        out_last_d  = out_valid_d && (out_cnt_d == (LOG2N)'(N - 1));
        out_re_d    = out_valid_d ? buf_re_d[out_cnt_d] : '0;
        out_im_d    = out_valid_d ? buf_im_d[out_cnt_d] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            bfly_q      <= '0;
            stage_q     <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            for (int i = 0; i < N; i++) begin
                buf_re_q[i] <= '0;
                buf_im_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            bfly_q      <= bfly_d;
            stage_q     <= stage_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            for (int i = 0; i < N; i++) begin
                buf_re_q[i] <= buf_re_d[i];
                buf_im_q[i] <= buf_im_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule

// File: tb/tb_ifft_core.sv
// Directed bench for ifft_core (N=16): reset, impulse, flat, tone, backpressure
// with in_valid held, and reset during COMPUTE.
module tb_ifft_core;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_re = '0;
    logic [7:0] in_im = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_re;
    logic [7:0] out_im;
    logic       out_last;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    int   frame_re [N];
    int   frame_im [N];
    int   got_re   [N];
    int   got_im   [N];
    logic got_last [N];
    int   lat;
    int   zero_bad;
    int   rdy_bad;
    int   stall_bad;
    bit   tmo;
    bit   keep_valid = 1'b0;

    // Exact tone outputs for X[1]=(64,0)
    int tone_re [N] = '{4, 3, 2, 1, 0, -2, -3, -4, -4, -4, -3, -2, 0, 1, 3, 4};
    int tone_im [N] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, -2, -3, -4, -4, -4, -3, -2};

    ifft_core #(.N(16), .LOG2N(4), .DW(8), .TW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            frame_re[i] = 0;
            frame_im[i] = 0;
        end
    endtask

    task automatic send_frame();
        int budget;
        tmo = 1'b0;
        for (int i = 0; i < N; i++) begin
            budget   = 0;
            in_valid = 1'b1;
            in_re    = 8'(frame_re[i]);
            in_im    = 8'(frame_im[i]);
            while (in_ready !== 1'b1 && budget < 200) begin
                @(posedge clk); #1;
                budget++;
            end
            if (budget >= 200) tmo = 1'b1;
            @(posedge clk); #1;
        end
        if (keep_valid) begin
            in_re = 8'h55;
            in_im = 8'hAA;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic collect_frame(input int stall_idx, input int stall_len);
        int budget;
        int idx;
        logic [7:0] hr, hi;
        logic hl;
        budget = 0; idx = 0; lat = 1;
        zero_bad = 0; rdy_bad = 0; stall_bad = 0;
        out_ready = 1'b1;
        while (idx < N && budget < 500) begin
            if (keep_valid && in_ready !== 1'b0) rdy_bad++;
            if (out_valid === 1'b1) begin
                got_re[idx]   = $signed(out_re);
                got_im[idx]   = $signed(out_im);
                got_last[idx] = out_last;
                if (idx == stall_idx) begin
                    hr = out_re; hi = out_im; hl = out_last;
                    out_ready = 1'b0;
                    for (int c = 0; c < stall_len; c++) begin
                        @(posedge clk); #1;
                        if (out_valid !== 1'b1 || out_re !== hr || out_im !== hi || out_last !== hl)
                            stall_bad++;
                    end
                    out_ready = 1'b1;
                end
                idx++;
            end else begin
                if (out_re !== 8'h00 || out_im !== 8'h00) zero_bad++;
                if (idx == 0) lat++;
            end
            @(posedge clk); #1;
            budget++;
        end
        if (idx < N) tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold got rdy=%b busy=%b vld=%b expected 1 0 0", in_ready, busy, out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
        vectors++;
        if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b expected 0", out_last); end
        vectors++;
        if (out_re !== 8'h00 || out_im !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out_data got %h/%h expected 00/00", out_re, out_im);
        end
    endtask

    task automatic test_impulse();
        clear_frame();
        frame_re[0] = 64;
        send_frame();
        collect_frame(-1, 0);
        vectors++;
        if (tmo) begin miscompares++; $display("FAIL impulse_timeout got timeout expected frame"); end
        vectors++;
        if (lat != 33) begin miscompares++; $display("FAIL impulse_latency got %0d expected 33", lat); end
        vectors++;
        if (zero_bad != 0) begin miscompares++; $display("FAIL impulse_idle_zero got %0d expected 0", zero_bad); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (got_re[i] != 4 || got_im[i] != 0) begin
                miscompares++;
                $display("FAIL impulse_out[%0d] got (%0d,%0d) expected (4,0)", i, got_re[i], got_im[i]);
            end
            vectors++;
            if (got_last[i] !== (i == N - 1)) begin
                miscompares++;
                $display("FAIL impulse_last[%0d] got %b expected %b", i, got_last[i], (i == N - 1));
            end
        end
    endtask

    task automatic test_flat();
        int er;
        for (int i = 0; i < N; i++) begin
            frame_re[i] = 16;
            frame_im[i] = 0;
        end
        send_frame();
        collect_frame(-1, 0);
        vectors++;
        if (tmo) begin miscompares++; $display("FAIL flat_timeout got timeout expected frame"); end
        for (int i = 0; i < N; i++) begin
            er = (i == 0) ? 16 : 0;
            vectors++;
            if (got_re[i] != er || got_im[i] != 0) begin
                miscompares++;
                $display("FAIL flat_out[%0d] got (%0d,%0d) expected (%0d,0)", i, got_re[i], got_im[i], er);
            end
        end
    endtask

    task automatic test_tone();
        int idx [4] = '{0, 4, 8, 12};
        int er  [4] = '{4, 0, -4, 0};
        int ei  [4] = '{0, 4, 0, -4};
        int dr, di;
        clear_frame();
        frame_re[1] = 64;
        send_frame();
        collect_frame(-1, 0);
        vectors++;
        if (tmo) begin miscompares++; $display("FAIL tone_timeout got timeout expected frame"); end
        for (int j = 0; j < 4; j++) begin
            dr = got_re[idx[j]] - er[j];
            di = got_im[idx[j]] - ei[j];
            vectors++;
            if (dr > 1 || dr < -1 || di > 1 || di < -1) begin
                miscompares++;
                $display("FAIL tone_out[%0d] got (%0d,%0d) expected (%0d,%0d)+-1",
                         idx[j], got_re[idx[j]], got_im[idx[j]], er[j], ei[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_frame();
        frame_re[1] = 64;
        keep_valid = 1'b1;
        send_frame();
        collect_frame(3, 5);
        keep_valid = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after got %b expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_after got %b expected 0", out_valid); end
        vectors++;
        if (tmo) begin miscompares++; $display("FAIL bp_timeout got timeout expected frame"); end
        vectors++;
        if (stall_bad != 0) begin miscompares++; $display("FAIL bp_stall_hold got %0d expected 0", stall_bad); end
        vectors++;
        if (rdy_bad != 0) begin miscompares++; $display("FAIL bp_in_ready_low got %0d expected 0", rdy_bad); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (got_re[i] != tone_re[i] || got_im[i] != tone_im[i]) begin
                miscompares++;
                $display("FAIL bp_out[%0d] got (%0d,%0d) expected (%0d,%0d)",
                         i, got_re[i], got_im[i], tone_re[i], tone_im[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        clear_frame();
        frame_re[0] = 64;
        send_frame();
        repeat (18) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before got %b expected 1", busy); end
        rst = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b expected 0", busy); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got %b expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got %b expected 0", out_valid); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send_frame();
        collect_frame(-1, 0);
        vectors++;
        if (tmo) begin miscompares++; $display("FAIL midrst_timeout got timeout expected frame"); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (got_re[i] != 4 || got_im[i] != 0) begin
                miscompares++;
                $display("FAIL midrst_out[%0d] got (%0d,%0d) expected (4,0)", i, got_re[i], got_im[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_flat();
        test_tone();
        test_backpressure();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
